// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: opcodes, FSM encoding,
// forwarding selects and the per-stage scoreboard entry.
package hazard_pkg;

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StLdStall = 2'b01,
        StFlush   = 2'b10,
        StFreeze  = 2'b11
    } hz_state_e;

    typedef enum logic [1:0] {
        FwdRf    = 2'b00,
        FwdExMem = 2'b01,
        FwdMemWb = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       is_load;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
    } sb_entry_t;

    // Loads in MEM have no data yet, so only ALU results forward from EX/MEM.
    function automatic logic [1:0] fwd_pick(input sb_entry_t mem, input sb_entry_t wb,
                                            input logic [4:0] rs, input logic use_rs);
        if (mem.valid && mem.wr && !mem.is_load && mem.rd == rs && use_rs) begin
            return FwdExMem;
        end else if (wb.valid && wb.wr && wb.rd == rs) begin
            return FwdMemWb;
        end
        return FwdRf;
    endfunction

endpackage

// File: rtl/hz_decode.sv
// Extracts register usage of one instruction into a scoreboard entry.
module hz_decode
    import hazard_pkg::*;
(
    input  logic [31:0] inst,
    output sb_entry_t   entry
);

    logic [6:0] opcode;
    logic       unused_bits;

    assign opcode      = inst[6:0];
    assign unused_bits = ^{inst[31:25], inst[14:12]};

    always_comb begin
        entry         = '0;
        entry.valid   = 1'b1;
        entry.rd      = inst[11:7];
        entry.rs1     = inst[19:15];
        entry.rs2     = inst[24:20];
        entry.use1    = opcode inside {OpReg, OpImm, OpLoad, OpStore, OpBranch, OpJalr};
        entry.use2    = opcode inside {OpReg, OpStore, OpBranch};
        entry.is_load = (opcode == OpLoad);
        // Writes to x0 are discarded, so they must never create a dependency.
        entry.wr      = (opcode inside {OpReg, OpImm, OpLoad, OpLui, OpAuipc, OpJal, OpJalr})
                        && (inst[11:7] != 5'd0);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: load-use stall, branch flush, memory freeze,
// operand forwarding and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_inst,
    input  logic        id_valid,
    input  logic        br_taken,
    input  logic        mem_busy,
    output logic        stall_fe,
    output logic        flush_fd,
    output logic        bubble_ex,
    output logic        freeze,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [1:0]  hz_state,
    output logic [15:0] stall_cycles
);

    sb_entry_t id_ent;
    sb_entry_t ex_q, mem_q, wb_q;
    hz_state_e state_q, state_d;
    logic [15:0] cnt_q;
    logic        load_use;

    hz_decode u_decode (
        .inst  (id_inst),
        .entry (id_ent)
    );

    assign load_use = id_valid && ex_q.valid && ex_q.is_load && ex_q.wr &&
                      ((id_ent.use1 && ex_q.rd == id_ent.rs1) ||
                       (id_ent.use2 && ex_q.rd == id_ent.rs2));

    // Outputs are gated by rst so the pipeline sees a quiet controller during reset.
    always_comb begin
        stall_fe  = 1'b0;
        flush_fd  = 1'b0;
        bubble_ex = 1'b0;
        freeze    = 1'b0;
        state_d   = StRun;
        if (!rst) begin
            if (mem_busy) begin
                freeze  = 1'b1;
                state_d = StFreeze;
            end else if (br_taken) begin
                flush_fd  = 1'b1;
                bubble_ex = 1'b1;
                state_d   = StFlush;
            end else if (load_use) begin
                stall_fe  = 1'b1;
                bubble_ex = 1'b1;
                state_d   = StLdStall;
            end
        end
    end

    assign fwd_a        = fwd_pick(mem_q, wb_q, ex_q.rs1, ex_q.use1);
    assign fwd_b        = fwd_pick(mem_q, wb_q, ex_q.rs2, ex_q.use2);
    assign hz_state     = state_q;
    assign stall_cycles = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!freeze) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= (bubble_ex || !id_valid) ? '0 : id_ent;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else if ((stall_fe || freeze) && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        br_taken;
    logic        mem_busy;
    logic        stall_fe, flush_fd, bubble_ex, freeze;
    logic [1:0]  fwd_a, fwd_b, hz_state;
    logic [15:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] Nop = 32'h0000_0013;

    hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_inst      (id_inst),
        .id_valid     (id_valid),
        .br_taken     (br_taken),
        .mem_busy     (mem_busy),
        .stall_fe     (stall_fe),
        .flush_fd     (flush_fd),
        .bubble_ex    (bubble_ex),
        .freeze       (freeze),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .hz_state     (hz_state),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {stall_fe, flush_fd, bubble_ex, freeze}
    function automatic logic [31:0] hz_bits();
        return {28'd0, stall_fe, flush_fd, bubble_ex, freeze};
    endfunction

    function automatic logic [31:0] fwd_bits();
        return {28'd0, fwd_a, fwd_b};
    endfunction

    function automatic logic [31:0] st();
        return {30'd0, hz_state};
    endfunction

    function automatic logic [31:0] cnt();
        return {16'd0, stall_cycles};
    endfunction

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] s_ins(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] ins, input logic v);
        id_inst  = ins;
        id_valid = v;
        #1;
    endtask

    initial begin
        logic [31:0] lw_x5, add_x6, add_x3, sub_x4, or_x8, addi_x0, add_x7;
        lw_x5   = i_ins(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011);
        add_x6  = r_ins(7'b0000000, 5'd2, 5'd5, 5'd6);
        add_x3  = r_ins(7'b0000000, 5'd2, 5'd1, 5'd3);
        sub_x4  = r_ins(7'b0100000, 5'd3, 5'd3, 5'd4);
        or_x8   = r_ins(7'b0000000, 5'd3, 5'd1, 5'd8);
        addi_x0 = i_ins(12'd1, 5'd0, 3'b000, 5'd0, 7'b0010011);
        add_x7  = r_ins(7'b0000000, 5'd0, 5'd0, 5'd7);

        // Reset with hazard inputs active: everything must read 0.
        rst = 1'b1; id_inst = Nop; id_valid = 1'b1; br_taken = 1'b1; mem_busy = 1'b1;
        #2;
        check("rst_hz", hz_bits(), 32'h0);
        check("rst_fwd", fwd_bits(), 32'h0);
        check("rst_state", st(), 32'h0);
        check("rst_cnt", cnt(), 32'h0);
        br_taken = 1'b0; mem_busy = 1'b0;
        #20 rst = 1'b0;

        // Load-use: lw x5,0(x1); add x6,x5,x2
        set_id(lw_x5, 1'b1);
        check("lu_pre", hz_bits(), 32'h0);
        step();
        set_id(add_x6, 1'b1);
        check("lu_stall", hz_bits(), 32'hA);
        step();
        check("lu_state", st(), 32'h1);
        check("lu_cnt1", cnt(), 32'd1);
        check("lu_once", hz_bits(), 32'h0);
        step();
        set_id(Nop, 1'b1);
        check("lu_fwd_wb", fwd_bits(), 32'b1000);
        check("lu_state_run", st(), 32'h0);
        check("lu_cnt_hold", cnt(), 32'd1);
        step();

        // ALU forwarding chain
        set_id(add_x3, 1'b1);
        step();
        set_id(sub_x4, 1'b1);
        check("alu_nostall", hz_bits(), 32'h0);
        step();
        set_id(or_x8, 1'b1);
        check("alu_fwd_exmem", fwd_bits(), 32'b0101);
        step();
        set_id(addi_x0, 1'b1);
        check("alu_fwd_wb_b", fwd_bits(), 32'b0010);
        step();

        // x0 never forwards
        set_id(add_x7, 1'b1);
        step();
        set_id(Nop, 1'b1);
        check("x0_fwd", fwd_bits(), 32'h0);
        step();

        // Load-use through rs2 of a store
        set_id(i_ins(12'd4, 5'd2, 3'b010, 5'd9, 7'b0000011), 1'b1);
        step();
        set_id(s_ins(12'd0, 5'd9, 5'd3), 1'b1);
        check("lu_rs2", hz_bits(), 32'hA);
        step();
        check("lu_rs2_cnt", cnt(), 32'd2);
        step();

        // Load to x0 creates no dependency
        set_id(i_ins(12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011), 1'b1);
        step();
        set_id(r_ins(7'b0000000, 5'd2, 5'd0, 5'd6), 1'b1);
        check("lu_x0", hz_bits(), 32'h0);
        step();

        // Invalid ID slot does not stall
        set_id(lw_x5, 1'b1);
        step();
        set_id(add_x6, 1'b0);
        check("lu_invalid", hz_bits(), 32'h0);
        step();

        // Branch beats simultaneous load-use; stall not counted
        set_id(lw_x5, 1'b1);
        step();
        set_id(add_x6, 1'b1);
        br_taken = 1'b1;
        #1;
        check("br_prio", hz_bits(), 32'h6);
        step();
        br_taken = 1'b0;
        set_id(Nop, 1'b0);
        check("br_state", st(), 32'h2);
        check("br_cnt", cnt(), 32'd2);
        step();

        // Freeze for 3 cycles: scoreboard holds EX=sub, MEM=add
        set_id(add_x3, 1'b1);
        step();
        set_id(sub_x4, 1'b1);
        step();
        set_id(Nop, 1'b1);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("frz_hz", hz_bits(), 32'h1);
            check("frz_fwd", fwd_bits(), 32'b0101);
            step();
            check("frz_state", st(), 32'h3);
        end
        mem_busy = 1'b0;
        #1;
        check("frz_cnt", cnt(), 32'd5);
        check("frz_fwd_after", fwd_bits(), 32'b0101);
        step();
        check("frz_shift", fwd_bits(), 32'h0);
        check("frz_state_run", st(), 32'h0);

        // Reset mid-stall
        set_id(lw_x5, 1'b1);
        step();
        set_id(add_x6, 1'b1);
        check("rs_stall", hz_bits(), 32'hA);
        mem_busy = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rs_hz", hz_bits(), 32'h0);
        check("rs_fwd", fwd_bits(), 32'h0);
        check("rs_cnt", cnt(), 32'h0);
        check("rs_state", st(), 32'h0);
        mem_busy = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("rs_empty_sb", hz_bits(), 32'h0);
        step();
        check("rs_state_run", st(), 32'h0);
        check("rs_cnt_zero", cnt(), 32'h0);

        // Saturation: freeze long enough to pass 16'hFFFF
        mem_busy = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        check("sat_reach", cnt(), 32'hFFFF);
        repeat (3) step();
        check("sat_hold", cnt(), 32'hFFFF);
        check("sat_frz", hz_bits(), 32'h1);
        mem_busy = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
